// File: rtl/spi_flash_dma_pkg.sv
// Shared definitions for the SPI flash DMA master: widths, register maps of
// the host port and of the downstream spi_flash, bit positions and FSM states.
package spi_flash_dma_pkg;

  localparam int unsigned BITS          = 16;
  localparam int unsigned ADDRESS_BITS  = 8;
  localparam int unsigned MEM_ADDR_BITS = 16;
  localparam int unsigned SRC_BITS      = 23;
  localparam int unsigned SRC_HI_BITS   = SRC_BITS - BITS;

  // spi_flash register offsets and command bits
  localparam logic [ADDRESS_BITS-1:0] FL_REG_ADDR_LO = ADDRESS_BITS'(0);
  localparam logic [ADDRESS_BITS-1:0] FL_REG_ADDR_HI = ADDRESS_BITS'(1);
  localparam logic [ADDRESS_BITS-1:0] FL_REG_CMD     = ADDRESS_BITS'(2);
  localparam logic [ADDRESS_BITS-1:0] FL_REG_DATA    = ADDRESS_BITS'(3);
  localparam logic [ADDRESS_BITS-1:0] FL_REG_STATUS  = ADDRESS_BITS'(4);
  localparam logic [BITS-1:0]         FL_CMD_GO      = BITS'(1);
  localparam logic [BITS-1:0]         FL_CMD_WAKE    = BITS'(2);

  // DMA host register offsets
  localparam logic [ADDRESS_BITS-1:0] DMA_REG_SRC_LO = ADDRESS_BITS'(0);
  localparam logic [ADDRESS_BITS-1:0] DMA_REG_SRC_HI = ADDRESS_BITS'(1);
  localparam logic [ADDRESS_BITS-1:0] DMA_REG_DST    = ADDRESS_BITS'(2);
  localparam logic [ADDRESS_BITS-1:0] DMA_REG_COUNT  = ADDRESS_BITS'(3);
  localparam logic [ADDRESS_BITS-1:0] DMA_REG_CTRL   = ADDRESS_BITS'(4);
  localparam logic [ADDRESS_BITS-1:0] DMA_REG_STATUS = ADDRESS_BITS'(5);

  localparam int unsigned CTRL_START      = 0;
  localparam int unsigned CTRL_ABORT      = 1;
  localparam int unsigned CTRL_IRQ_EN     = 2;
  localparam int unsigned CTRL_WAKE_FIRST = 3;
  localparam int unsigned STAT_BUSY       = 0;
  localparam int unsigned STAT_DONE       = 1;
  localparam int unsigned STAT_ABORTED    = 2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WAKE   = 4'd1,
    S_WGUARD = 4'd2,
    S_WPOLL  = 4'd3,
    S_SET_LO = 4'd4,
    S_SET_HI = 4'd5,
    S_GO     = 4'd6,
    S_GUARD  = 4'd7,
    S_POLL   = 4'd8,
    S_READ   = 4'd9,
    S_MEMWR  = 4'd10,
    S_NEXT   = 4'd11,
    S_DONE   = 4'd12
  } state_t;

endpackage

// File: rtl/spi_flash_dma.sv
// DMA master for spi_flash: copies COUNT 16-bit words from flash byte address
// SRC into memory starting at word address DST, programmed over a host port.
module spi_flash_dma
  import spi_flash_dma_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ADDRESS_BITS-1:0]  HOST_ADDRESS,
  input  logic [BITS-1:0]          HOST_DATA_IN,
  input  logic                     HOST_WR,
  output logic [BITS-1:0]          HOST_DATA_OUT,
  output logic [ADDRESS_BITS-1:0]  FL_ADDRESS,
  output logic [BITS-1:0]          FL_DATA_IN,
  output logic                     FL_WR,
  input  logic [BITS-1:0]          FL_DATA_OUT,
  output logic [MEM_ADDR_BITS-1:0] MEM_ADDR,
  output logic [BITS-1:0]          MEM_DATA,
  output logic                     MEM_WR,
  input  logic                     MEM_READY,
  output logic                     IRQ
);

  state_t                   state, state_d;
  logic [BITS-1:0]          src_lo, src_lo_d;
  logic [SRC_HI_BITS-1:0]   src_hi, src_hi_d;
  logic [MEM_ADDR_BITS-1:0] dst, dst_d;
  logic [BITS-1:0]          count, count_d;
  logic                     irq_en, irq_en_d, wake_first, wake_first_d;
  logic                     busy, busy_d, done, done_d, aborted, aborted_d;
  logic                     abort_flag, abort_flag_d, guard_cnt, guard_cnt_d;
  logic [SRC_BITS-1:0]      w_src, w_src_d;
  logic [MEM_ADDR_BITS-1:0] w_dst, w_dst_d;
  logic [BITS-1:0]          w_count, w_count_d;
  logic [ADDRESS_BITS-1:0]  fl_address_d;
  logic [BITS-1:0]          fl_data_in_d, mem_data_d;
  logic [MEM_ADDR_BITS-1:0] mem_addr_d;
  logic                     fl_wr_d, mem_wr_d, irq_d, start_req;

  // State and register file
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      src_lo     <= '0;
      src_hi     <= '0;
      dst        <= '0;
      count      <= '0;
      irq_en     <= 1'b0;
      wake_first <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_flag <= 1'b0;
      guard_cnt  <= 1'b0;
      w_src      <= '0;
      w_dst      <= '0;
      w_count    <= '0;
      FL_WR      <= 1'b0;
      FL_ADDRESS <= FL_REG_STATUS;
      FL_DATA_IN <= '0;
      MEM_WR     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_DATA   <= '0;
      IRQ        <= 1'b0;
    end else begin
      state      <= state_d;
      src_lo     <= src_lo_d;
      src_hi     <= src_hi_d;
      dst        <= dst_d;
      count      <= count_d;
      irq_en     <= irq_en_d;
      wake_first <= wake_first_d;
      busy       <= busy_d;
      done       <= done_d;
      aborted    <= aborted_d;
      abort_flag <= abort_flag_d;
      guard_cnt  <= guard_cnt_d;
      w_src      <= w_src_d;
      w_dst      <= w_dst_d;
      w_count    <= w_count_d;
      FL_WR      <= fl_wr_d;
      FL_ADDRESS <= fl_address_d;
      FL_DATA_IN <= fl_data_in_d;
      MEM_WR     <= mem_wr_d;
      MEM_ADDR   <= mem_addr_d;
      MEM_DATA   <= mem_data_d;
      IRQ        <= irq_d;
    end
  end

  // Host writes, sequencing, and outputs decoded from the next state
  always_comb begin
    state_d      = state;
    src_lo_d     = src_lo;
    src_hi_d     = src_hi;
    dst_d        = dst;
    count_d      = count;
    irq_en_d     = irq_en;
    wake_first_d = wake_first;
    busy_d       = busy;
    done_d       = done;
    aborted_d    = aborted;
    abort_flag_d = abort_flag;
    guard_cnt_d  = 1'b0;
    w_src_d      = w_src;
    w_dst_d      = w_dst;
    w_count_d    = w_count;
    fl_wr_d      = 1'b0;
    fl_address_d = FL_REG_STATUS;
    fl_data_in_d = FL_DATA_IN;
    mem_wr_d     = 1'b0;
    mem_addr_d   = MEM_ADDR;
    mem_data_d   = MEM_DATA;
    start_req    = HOST_WR && (HOST_ADDRESS == DMA_REG_CTRL) && HOST_DATA_IN[CTRL_START]
                   && !HOST_DATA_IN[CTRL_ABORT] && !busy;

    if (HOST_WR) begin
      case (HOST_ADDRESS)
        DMA_REG_SRC_LO: if (!busy) src_lo_d = HOST_DATA_IN;
        DMA_REG_SRC_HI: if (!busy) src_hi_d = HOST_DATA_IN[SRC_HI_BITS-1:0];
        DMA_REG_DST:    if (!busy) dst_d = HOST_DATA_IN;
        DMA_REG_COUNT:  if (!busy) count_d = HOST_DATA_IN;
        DMA_REG_CTRL: begin
          irq_en_d     = HOST_DATA_IN[CTRL_IRQ_EN];
          wake_first_d = HOST_DATA_IN[CTRL_WAKE_FIRST];
          if (HOST_DATA_IN[CTRL_ABORT] && busy) abort_flag_d = 1'b1;
        end
        DMA_REG_STATUS: if (HOST_DATA_IN[STAT_DONE]) begin
          done_d    = 1'b0;
          aborted_d = 1'b0;
        end
        default: ;
      endcase
    end

    case (state)
      S_IDLE: if (start_req) begin
        w_src_d      = {src_hi, src_lo};
        w_dst_d      = dst;
        w_count_d    = count;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        abort_flag_d = 1'b0;
        if (count == '0)       state_d = S_DONE;
        else if (wake_first_d) state_d = S_WAKE;
        else                   state_d = S_SET_LO;
      end
      S_WAKE:   state_d = S_WGUARD;
      S_WGUARD, S_GUARD: begin
        guard_cnt_d = !guard_cnt;
        if (guard_cnt) state_d = (state == S_WGUARD) ? S_WPOLL : S_POLL;
      end
      // A pending abort is honoured only once the flash transaction has finished
      S_WPOLL:  if (FL_DATA_OUT[0]) state_d = abort_flag ? S_DONE : S_SET_LO;
      S_SET_LO: state_d = S_SET_HI;
      S_SET_HI: state_d = S_GO;
      S_GO:     state_d = S_GUARD;
      S_POLL:   if (FL_DATA_OUT[0]) state_d = abort_flag ? S_DONE : S_READ;
      S_READ: begin
        mem_data_d = FL_DATA_OUT;
        state_d    = S_MEMWR;
      end
      S_MEMWR:  if (MEM_READY) state_d = S_NEXT;
      S_NEXT: begin
        w_src_d   = w_src + SRC_BITS'(2);
        w_dst_d   = w_dst + MEM_ADDR_BITS'(1);
        w_count_d = w_count - BITS'(1);
        state_d   = (w_count == BITS'(1) || abort_flag) ? S_DONE : S_SET_LO;
      end
      S_DONE: begin
        busy_d       = 1'b0;
        done_d       = 1'b1;
        aborted_d    = abort_flag;
        abort_flag_d = 1'b0;
        state_d      = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase

    case (state_d)
      S_WAKE: begin
        fl_wr_d      = 1'b1;
        fl_address_d = FL_REG_CMD;
        fl_data_in_d = FL_CMD_WAKE;
      end
      S_SET_LO: begin
        fl_wr_d      = 1'b1;
        fl_address_d = FL_REG_ADDR_LO;
        fl_data_in_d = w_src_d[BITS-1:0];
      end
      S_SET_HI: begin
        fl_wr_d      = 1'b1;
        fl_address_d = FL_REG_ADDR_HI;
        fl_data_in_d = BITS'(w_src_d[SRC_BITS-1:BITS]);
      end
      S_GO: begin
        fl_wr_d      = 1'b1;
        fl_address_d = FL_REG_CMD;
        fl_data_in_d = FL_CMD_GO;
      end
      S_READ:  fl_address_d = FL_REG_DATA;
      S_MEMWR: begin
        mem_wr_d   = 1'b1;
        mem_addr_d = w_dst_d;
      end
      default: ;
    endcase

    irq_d = done_d & irq_en_d;
  end

  // Host read mux
  always_comb begin
    HOST_DATA_OUT = '0;
    case (HOST_ADDRESS)
      DMA_REG_SRC_LO: HOST_DATA_OUT = src_lo;
      DMA_REG_SRC_HI: HOST_DATA_OUT = BITS'(src_hi);
      DMA_REG_DST:    HOST_DATA_OUT = dst;
      DMA_REG_COUNT:  HOST_DATA_OUT = count;
      DMA_REG_CTRL: begin
        HOST_DATA_OUT[CTRL_IRQ_EN]     = irq_en;
        HOST_DATA_OUT[CTRL_WAKE_FIRST] = wake_first;
      end
      DMA_REG_STATUS: begin
        HOST_DATA_OUT[STAT_BUSY]    = busy;
        HOST_DATA_OUT[STAT_DONE]    = done;
        HOST_DATA_OUT[STAT_ABORTED] = aborted;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_dma.sv
// Bench for spi_flash_dma: behavioural spi_flash and memory models, a job
// table with randomized entries checked against a reference copy model.
module tb_spi_flash_dma;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  HOST_ADDRESS;
  logic [15:0] HOST_DATA_IN;
  logic        HOST_WR;
  logic [15:0] HOST_DATA_OUT;
  logic [7:0]  FL_ADDRESS;
  logic [15:0] FL_DATA_IN;
  logic        FL_WR;
  logic [15:0] FL_DATA_OUT;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_DATA;
  logic        MEM_WR;
  logic        MEM_READY;
  logic        IRQ;

  spi_flash_dma dut (
    .CLK(CLK), .RST(RST),
    .HOST_ADDRESS(HOST_ADDRESS), .HOST_DATA_IN(HOST_DATA_IN), .HOST_WR(HOST_WR),
    .HOST_DATA_OUT(HOST_DATA_OUT),
    .FL_ADDRESS(FL_ADDRESS), .FL_DATA_IN(FL_DATA_IN), .FL_WR(FL_WR), .FL_DATA_OUT(FL_DATA_OUT),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_WR(MEM_WR), .MEM_READY(MEM_READY),
    .IRQ(IRQ)
  );

  initial forever #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Flash contents: byte at address a is a[7:0] ^ a[22:16]; words are big-endian
  function automatic logic [7:0] fbyte(input logic [22:0] a);
    return a[7:0] ^ {1'b0, a[22:16]};
  endfunction

  function automatic logic [15:0] word_at(input logic [22:0] a);
    logic [22:0] b;
    b = a + 23'd1;
    return {fbyte(a), fbyte(b)};
  endfunction

  // Behavioural spi_flash register port
  logic [22:0] fa;
  logic        fl_done, fl_is_go;
  logic [15:0] fl_word;
  int          fl_cnt;
  bit          lat_long = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      fa <= '0; fl_done <= 1'b0; fl_is_go <= 1'b0; fl_word <= '0; fl_cnt <= 0;
    end else begin
      if (fl_cnt == 1) begin
        fl_done <= 1'b1;
        if (fl_is_go) fl_word <= word_at(fa);
      end
      if (fl_cnt != 0) fl_cnt <= fl_cnt - 1;
      if (FL_WR) begin
        case (FL_ADDRESS)
          8'd0: fa[15:0] <= FL_DATA_IN;
          8'd1: fa[22:16] <= FL_DATA_IN[6:0];
          8'd2: if (FL_DATA_IN[1:0] != 2'b00) begin
            fl_done  <= 1'b0;
            fl_is_go <= FL_DATA_IN[0];
            fl_cnt   <= lat_long ? 20 : int'($urandom_range(1, 6));
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (FL_ADDRESS)
      8'd3:    FL_DATA_OUT = fl_word;
      8'd4:    FL_DATA_OUT = {15'd0, fl_done};
      default: FL_DATA_OUT = 16'h0000;
    endcase
  end

  // Transaction logs of accepted memory writes and flash register writes
  typedef struct packed { logic [15:0] a; logic [15:0] d; } xfer_t;
  typedef struct packed { logic [7:0] a; logic [15:0] d; } flw_t;
  xfer_t got_q[$];
  flw_t  fl_q[$];

  always @(posedge CLK) begin
    if (!RST) begin
      if (MEM_WR && MEM_READY) got_q.push_back({MEM_ADDR, MEM_DATA});
      if (FL_WR) fl_q.push_back({FL_ADDRESS, FL_DATA_IN});
    end
  end

  bit stall = 1'b0;
  bit rnd_ready = 1'b1;
  initial begin
    MEM_READY = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      MEM_READY = stall ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  typedef struct {
    logic [22:0] src;
    logic [15:0] dst;
    logic [15:0] cnt;
    bit          wake;
    bit          irq_en;
    logic [15:0] exp_status;
    bit          exp_irq;
  } vec_t;
  vec_t vecs[8];

  // Reference: word i of a job lands at dst+i with the flash word at src+2i
  function automatic xfer_t exp_xfer(input logic [22:0] src, input logic [15:0] dst, input int i);
    logic [22:0] a;
    a = src + 23'(2 * i);
    return {dst + 16'(i), word_at(a)};
  endfunction

  task automatic host_wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge CLK);
    HOST_ADDRESS = a; HOST_DATA_IN = d; HOST_WR = 1'b1;
    @(negedge CLK);
    HOST_WR = 1'b0;
  endtask

  task automatic host_rd(input logic [7:0] a, output logic [15:0] d);
    HOST_ADDRESS = a;
    #1;
    d = HOST_DATA_OUT;
  endtask

  task automatic wait_done(input string name);
    logic [15:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      host_rd(8'd5, s);
      if (s[1:0] == 2'b10) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL %s: done wait expired, status 0x%0h, required done", name, s);
    end
  endtask

  task automatic wait_got(input string name, input int base, input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (got_q.size() - base >= n) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL %s: word wait expired, got %0d words, required %0d", name, got_q.size() - base, n);
    end
  endtask

  task automatic wait_flash_busy(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (fl_cnt > 0) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL %s: flash transaction wait expired, got idle, required busy", name);
    end
  endtask

  task automatic start_job(input vec_t v);
    host_wr(8'd5, 16'h0002);
    host_wr(8'd0, v.src[15:0]);
    host_wr(8'd1, {9'd0, v.src[22:16]});
    host_wr(8'd2, v.dst);
    host_wr(8'd3, v.cnt);
    host_wr(8'd4, {12'd0, v.wake, v.irq_en, 2'b01});
  endtask

  task automatic check_writes(input string name, input vec_t v, input int base, input int nexp);
    xfer_t e;
    check({name, "_nwords"}, 32'(got_q.size() - base), 32'(nexp));
    for (int i = 0; i < nexp && base + i < got_q.size(); i++) begin
      e = exp_xfer(v.src, v.dst, i);
      check($sformatf("%s_addr%0d", name, i), 32'(got_q[base + i].a), 32'(e.a));
      check($sformatf("%s_data%0d", name, i), 32'(got_q[base + i].d), 32'(e.d));
    end
  endtask

  task automatic run_job(input string name, input vec_t v, output int base);
    logic [15:0] s;
    int fbase;
    base  = got_q.size();
    fbase = fl_q.size();
    start_job(v);
    wait_done(name);
    host_rd(8'd5, s);
    check({name, "_status"}, 32'(s), 32'(v.exp_status));
    check({name, "_irq"}, 32'(IRQ), 32'(v.exp_irq));
    check_writes(name, v, base, int'(v.cnt));
    if (v.wake) begin
      if (fl_q.size() > fbase + 1) begin
        check({name, "_wake_cmd"}, 32'(fl_q[fbase]), 32'({8'd2, 16'h0002}));
        check({name, "_wake_then_lo"}, 32'(fl_q[fbase + 1].a), 32'd0);
      end else begin
        check({name, "_wake_log"}, 32'(fl_q.size() - fbase), 32'd2);
      end
    end
  endtask

  initial begin
    logic [15:0] s;
    int          base, fbase;
    vec_t        v;
    bit          ok;

    HOST_ADDRESS = '0; HOST_DATA_IN = '0; HOST_WR = 1'b0;
    vecs[0] = '{23'h000100, 16'h2000, 16'd4, 1'b0, 1'b0, 16'h0002, 1'b0};
    vecs[1] = '{23'h7FFFFE, 16'hFFFF, 16'd2, 1'b0, 1'b1, 16'h0002, 1'b1};
    vecs[2] = '{23'h001234, 16'h0100, 16'd3, 1'b1, 1'b0, 16'h0002, 1'b0};
    for (int i = 3; i < 8; i++) begin
      vecs[i].src        = 23'($urandom) & 23'h7FFFFE;
      vecs[i].dst        = 16'($urandom);
      vecs[i].cnt        = 16'($urandom_range(1, 5));
      vecs[i].wake       = 1'($urandom_range(0, 1));
      vecs[i].irq_en     = 1'($urandom_range(0, 1));
      vecs[i].exp_status = 16'h0002;
      vecs[i].exp_irq    = vecs[i].irq_en;
    end

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    check("rst_fl_address", 32'(FL_ADDRESS), 32'd4);
    check("rst_fl_wr", 32'(FL_WR), 32'd0);
    check("rst_fl_data_in", 32'(FL_DATA_IN), 32'd0);
    check("rst_mem_wr", 32'(MEM_WR), 32'd0);
    check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
    check("rst_mem_data", 32'(MEM_DATA), 32'd0);
    check("rst_irq", 32'(IRQ), 32'd0);
    for (int a = 0; a < 6; a++) begin
      host_rd(8'(a), s);
      check($sformatf("rst_reg%0d", a), 32'(s), 32'd0);
    end

    host_wr(8'd1, 16'hFFFF);
    host_rd(8'd1, s);
    check("src_hi_mask", 32'(s), 32'h007F);
    host_wr(8'd2, 16'hABCD);
    host_rd(8'd2, s);
    check("dst_readback", 32'(s), 32'hABCD);
    host_rd(8'd7, s);
    check("unmapped_read", 32'(s), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_job($sformatf("job%0d", i), vecs[i], base);
      if (i == 0 && got_q.size() >= base + 4) begin
        check("job0_word0_const", 32'(got_q[base].d), 32'h0001);
        check("job0_word3_const", 32'(got_q[base + 3]), 32'h2003_0607);
      end
      if (i == 1 && got_q.size() >= base + 2)
        check("wrap_word1_const", 32'(got_q[base + 1]), 32'h0000_0001);
    end

    // COUNT=0 with IRQ_EN finishes at once without touching flash or memory
    host_wr(8'd5, 16'h0002);
    host_wr(8'd3, 16'd0);
    base = got_q.size(); fbase = fl_q.size();
    host_wr(8'd4, 16'h0005);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      host_rd(8'd5, s);
      if (s == 16'h0002) break;
    end
    check("cnt0_status", 32'(s), 32'h0002);
    check("cnt0_irq", 32'(IRQ), 32'd1);
    check("cnt0_fl_wr", 32'(fl_q.size() - fbase), 32'd0);
    check("cnt0_mem_wr", 32'(got_q.size() - base), 32'd0);
    host_wr(8'd5, 16'h0002);
    host_rd(8'd5, s);
    check("clear_status", 32'(s), 32'd0);
    check("clear_irq", 32'(IRQ), 32'd0);

    // Memory stall of 10 cycles on word 1
    rnd_ready = 1'b0;
    v = '{23'h000400, 16'h3000, 16'd3, 1'b0, 1'b0, 16'h0002, 1'b0};
    base = got_q.size();
    start_job(v);
    wait_got("stall_w0", base, 1);
    stall = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (MEM_WR) begin ok = 1'b1; break; end
    end
    check("stall_memwr_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check($sformatf("stall_wr_c%0d", i), 32'(MEM_WR), 32'd1);
      check($sformatf("stall_bus_c%0d", i), 32'({MEM_ADDR, MEM_DATA}), 32'(exp_xfer(v.src, v.dst, 1)));
    end
    stall = 1'b0;
    wait_done("stall");
    check_writes("stall", v, base, 3);
    rnd_ready = 1'b1;

    // ABORT during word 3's flash transaction
    lat_long = 1'b1;
    v = '{23'h000800, 16'h4000, 16'd8, 1'b0, 1'b0, 16'h0006, 1'b0};
    base = got_q.size();
    start_job(v);
    wait_got("abort_w3", base, 3);
    wait_flash_busy("abort");
    host_wr(8'd4, 16'h0002);
    wait_done("abort");
    host_rd(8'd5, s);
    check("abort_status", 32'(s), 32'h0006);
    check_writes("abort", v, base, 3);
    lat_long = 1'b0;

    // ABORT while idle, and START+ABORT together, do nothing
    host_wr(8'd5, 16'h0002);
    host_wr(8'd4, 16'h0002);
    host_rd(8'd5, s);
    check("abort_idle_status", 32'(s), 32'd0);
    fbase = fl_q.size();
    host_wr(8'd3, 16'd2);
    host_wr(8'd4, 16'h0003);
    repeat (5) @(negedge CLK);
    host_rd(8'd5, s);
    check("start_abort_status", 32'(s), 32'd0);
    check("start_abort_fl_wr", 32'(fl_q.size() - fbase), 32'd0);

    // Reset mid-word, then a single-word job
    lat_long = 1'b1;
    v = '{23'h000600, 16'h4800, 16'd3, 1'b0, 1'b0, 16'h0002, 1'b0};
    start_job(v);
    wait_flash_busy("rst_mid");
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    host_rd(8'd5, s);
    check("rst_mid_status", 32'(s), 32'd0);
    check("rst_mid_fl_addr", 32'(FL_ADDRESS), 32'd4);
    check("rst_mid_mem_wr", 32'(MEM_WR), 32'd0);
    lat_long = 1'b0;
    v = '{23'h000A00, 16'h5000, 16'd1, 1'b0, 1'b1, 16'h0002, 1'b1};
    run_job("after_rst", v, base);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
